// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
// SPI responder that runs entirely on the system clock. It synchronises the SPI
// pins, detects sclk edges, and shifts DW-bit frames MSB-first in any of the
// four SPI modes. A one-entry transmit buffer feeds the shifter, and a strobe
// marks each complete receive word.
//
// Ports
//   clk, rst             system clock, synchronous active-high reset
//   sclk, ss, mosi       SPI pins from the master (asynchronous to clk)
//   miso, miso_oe        slave-out data and its output enable
//   mode                 {CPOL, CPHA}, latched when ss is asserted
//   tx_data, tx_valid    next word to send; accepted when tx_valid && tx_ready
//   tx_ready             transmit buffer empty
//   rx_data, rx_valid    last complete received word, one-clk update strobe
//   tx_underrun          one-clk pulse when a frame starts with no word queued
//   frame_err            one-clk pulse when ss rises part-way through a frame
//   busy                 frame in progress
// -----------------------------------------------------------------------------
module spi_slave #(
    parameter int              DW          = 8,
    parameter int              SYNC_STAGES = 2,
    parameter logic [DW-1:0]   FILL        = DW'(8'hFF)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sclk,
    input  logic          ss,
    input  logic          mosi,
    output logic          miso,
    output logic          miso_oe,
    input  logic [1:0]    mode,
    input  logic [DW-1:0] tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic [DW-1:0] rx_data,
    output logic          rx_valid,
    output logic          tx_underrun,
    output logic          frame_err,
    output logic          busy
);

    localparam int CW = (DW > 2) ? $clog2(DW) : 1;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   ss_prev_q, ss_prev_d;
    logic                   cpol_q, cpol_d;
    logic                   cpha_q, cpha_d;
    logic [DW-1:0]          tx_shift_q, tx_shift_d;
    // Only the DW-1 bits already received need storing; the last bit comes
    // straight from mosi_s when the word completes.
    logic [DW-2:0]          rx_shift_q, rx_shift_d;
    logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
    logic                   first_q, first_d;
    logic                   reload_q, reload_d;
    logic [DW-1:0]          buf_q, buf_d;
    logic                   buf_full_q, buf_full_d;
    logic [DW-1:0]          rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   tx_underrun_q, tx_underrun_d;
    logic                   frame_err_q, frame_err_d;

    logic sclk_s, ss_s, mosi_s;
    logic sclk_chg, lead_e, trail_e, sample_e, shift_e;
    logic ss_fall, ss_rise;
    logic wr, load;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s   = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d       = state_q;
        sclk_sync_d   = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        ss_sync_d     = {ss_sync_q[SYNC_STAGES-2:0], ss};
        mosi_sync_d   = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sclk_prev_d   = sclk_s;
        ss_prev_d     = ss_s;
        cpol_d        = cpol_q;
        cpha_d        = cpha_q;
        tx_shift_d    = tx_shift_q;
        rx_shift_d    = rx_shift_q;
        bit_cnt_d     = bit_cnt_q;
        first_d       = first_q;
        reload_d      = reload_q;
        buf_d         = buf_q;
        buf_full_d    = buf_full_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        tx_underrun_d = 1'b0;
        frame_err_d   = 1'b0;
        load          = 1'b0;
        wr            = tx_valid && !buf_full_q;

        // Edge classification relative to the CPOL idle level of this frame.
        sclk_chg = sclk_s ^ sclk_prev_q;
        lead_e   = sclk_chg && (sclk_s != cpol_q);
        trail_e  = sclk_chg && (sclk_s == cpol_q);
        sample_e = cpha_q ? trail_e : lead_e;
        shift_e  = cpha_q ? lead_e  : trail_e;
        ss_fall  = ss_prev_q && !ss_s;
        ss_rise  = !ss_prev_q && ss_s;

        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d    = ACTIVE;
                    cpol_d     = mode[1];
                    cpha_d     = mode[0];
                    load       = 1'b1;
                    first_d    = mode[0];
                    reload_d   = 1'b0;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    first_d   = 1'b0;
                    reload_d  = 1'b0;
                    if (bit_cnt_q != '0) begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    if (sample_e) begin
                        rx_shift_d = {rx_shift_q[DW-3:0], mosi_s};
                        if (bit_cnt_q == CW'(DW-1)) begin
                            rx_data_d  = {rx_shift_q, mosi_s};
                            rx_valid_d = 1'b1;
                            bit_cnt_d  = '0;
                            reload_d   = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CW'(1);
                        end
                    end
                    if (shift_e) begin
                        // A pending frame boundary replaces the shift with a
                        // reload; for CPHA=1 that reload is also the new
                        // frame's non-shifting first edge.
                        if (reload_q) begin
                            load     = 1'b1;
                            reload_d = 1'b0;
                            first_d  = 1'b0;
                        end else if (first_q) begin
                            first_d = 1'b0;
                        end else begin
                            tx_shift_d = {tx_shift_q[DW-2:0], 1'b0};
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The load always takes the buffer's current contents, so a write in
        // the same cycle lands in the buffer for the following frame.
        if (load) begin
            if (buf_full_q) begin
                tx_shift_d = buf_q;
                buf_full_d = 1'b0;
            end else begin
                tx_shift_d    = FILL;
                tx_underrun_d = 1'b1;
            end
        end
        if (wr) begin
            buf_d      = tx_data;
            buf_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            sclk_sync_q   <= '0;
            // ss idles high, so its synchroniser resets to the deasserted
            // level to avoid a phantom select edge after reset.
            ss_sync_q     <= '1;
            mosi_sync_q   <= '0;
            sclk_prev_q   <= 1'b0;
            ss_prev_q     <= 1'b1;
            cpol_q        <= 1'b0;
            cpha_q        <= 1'b0;
            tx_shift_q    <= '0;
            rx_shift_q    <= '0;
            bit_cnt_q     <= '0;
            first_q       <= 1'b0;
            reload_q      <= 1'b0;
            buf_q         <= '0;
            buf_full_q    <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            sclk_sync_q   <= sclk_sync_d;
            ss_sync_q     <= ss_sync_d;
            mosi_sync_q   <= mosi_sync_d;
            sclk_prev_q   <= sclk_prev_d;
            ss_prev_q     <= ss_prev_d;
            cpol_q        <= cpol_d;
            cpha_q        <= cpha_d;
            tx_shift_q    <= tx_shift_d;
            rx_shift_q    <= rx_shift_d;
            bit_cnt_q     <= bit_cnt_d;
            first_q       <= first_d;
            reload_q      <= reload_d;
            buf_q         <= buf_d;
            buf_full_q    <= buf_full_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            tx_underrun_q <= tx_underrun_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign miso        = (state_q == ACTIVE) && tx_shift_q[DW-1];
    assign miso_oe     = (state_q == ACTIVE);
    assign busy        = (state_q == ACTIVE);
    assign tx_ready    = !buf_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = tx_underrun_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave
// Directed and randomised SPI exchanges against spi_slave. A bit-level master
// drives the pins; expected words come from a word-level model of the
// transmit buffer (each frame load takes the next queued word or FILL).
// -----------------------------------------------------------------------------
module tb_spi_slave;

    localparam int H = 4;              // sclk half-period in clk cycles
    localparam logic [7:0] FILLV = 8'hFF;

    logic       clk, rst, sclk, ss, mosi, miso, miso_oe;
    logic [1:0] mode;
    logic [7:0] tx_data, rx_data;
    logic       tx_valid, tx_ready, rx_valid, tx_underrun, frame_err, busy;

    spi_slave #(.DW(8), .SYNC_STAGES(2), .FILL(8'hFF)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .ss(ss), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .mode(mode),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun),
        .frame_err(frame_err), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor: event counters and received-word log.
    int         n_und  = 0;
    int         n_ferr = 0;
    logic [7:0] rx_log[$];
    int         und_at_rxv[$];

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rx_valid === 1'b1) begin
                rx_log.push_back(rx_data);
                und_at_rxv.push_back(n_und);
            end
            if (tx_underrun === 1'b1) n_und++;
            if (frame_err === 1'b1) n_ferr++;
        end
    end

    // Feeder: presents queued words to the transmit buffer.
    logic [7:0] txq[$];
    int         tx_idx = 0;
    bit         acc = 1'b0;

    initial begin
        tx_valid = 1'b0;
        tx_data  = '0;
        forever begin
            @(negedge clk);
            if (acc) tx_idx++;
            if (tx_idx < txq.size()) begin
                tx_valid = 1'b1;
                tx_data  = txq[tx_idx];
            end else begin
                tx_valid = 1'b0;
                tx_data  = '0;
            end
            acc = tx_valid && tx_ready && !rst;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, required completion)");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Master: drives mq words MSB-first, collects miso words into misoq.
    logic [7:0] mq[$];
    logic [7:0] misoq[$];

    task automatic spi_xfer(input logic [1:0] m, input int nbits, input bit release_ss);
        logic [7:0] cur;
        logic       sb;
        cur   = '0;
        mode  = m;
        sclk  = m[1];
        mosi  = mq[0][7];
        repeat (4) @(negedge clk);
        ss = 1'b0;
        repeat (H) @(negedge clk);
        chk("busy_in_frame", {31'd0, busy}, 32'd1);
        chk("oe_in_frame", {31'd0, miso_oe}, 32'd1);
        for (int i = 0; i < nbits; i++) begin
            if (!m[0]) begin
                sb   = miso;
                sclk = ~m[1];
                repeat (H) @(negedge clk);
                sclk = m[1];
                if (i + 1 < nbits) mosi = mq[(i + 1) / 8][7 - ((i + 1) % 8)];
                repeat (H) @(negedge clk);
            end else begin
                sclk = ~m[1];
                mosi = mq[i / 8][7 - (i % 8)];
                repeat (H) @(negedge clk);
                sb   = miso;
                sclk = m[1];
                repeat (H) @(negedge clk);
            end
            cur = {cur[6:0], sb};
            if (i % 8 == 7) misoq.push_back(cur);
        end
        if (release_ss) begin
            ss = 1'b1;
            repeat (2 * H) @(negedge clk);
        end
    endtask

    // One complete exchange of nw words with the words in case_tx queued.
    logic [7:0] case_tx[$];
    logic [7:0] case_mosi[$];
    int         und_before_last;

    task automatic run_case(input string tag, input logic [1:0] m, input int nw);
        int         rxb, und0, ferr0, loads, ntx;
        logic [7:0] expw, got;
        rxb   = rx_log.size();
        und0  = n_und;
        ferr0 = n_ferr;
        ntx   = case_tx.size();
        // Every frame start loads once; CPHA=0 also reloads on the trailing
        // edge after the final bit, before ss rises.
        loads = nw + (m[0] ? 0 : 1);
        foreach (case_tx[k]) txq.push_back(case_tx[k]);
        repeat (4) @(negedge clk);
        mq = case_mosi;
        misoq.delete();
        spi_xfer(m, nw * 8, 1'b1);
        chk($sformatf("%s rx_count", tag), rx_log.size() - rxb, nw);
        for (int k = 0; k < nw; k++) begin
            expw = (k < ntx) ? case_tx[k] : FILLV;
            got  = (k < misoq.size()) ? misoq[k] : 8'hxx;
            chk($sformatf("%s miso_w%0d", tag, k), {24'd0, got}, {24'd0, expw});
            got  = (rxb + k < rx_log.size()) ? rx_log[rxb + k] : 8'hxx;
            chk($sformatf("%s rx_w%0d", tag, k), {24'd0, got}, {24'd0, case_mosi[k]});
        end
        chk($sformatf("%s underruns", tag), n_und - und0, (loads > ntx) ? loads - ntx : 0);
        chk($sformatf("%s frame_err", tag), n_ferr - ferr0, 0);
        chk($sformatf("%s tx_ready_after", tag), {31'd0, tx_ready}, 32'd1);
        und_before_last = (und_at_rxv.size() > 0) ? und_at_rxv[$] - und0 : -1;
    endtask

    initial begin
        logic [1:0] m;
        logic [7:0] w, prev_rx;
        int         nw, ntx, rxb, ferr0, und0;

        rst = 1'b1; ss = 1'b1; sclk = 1'b0; mosi = 1'b0; mode = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst miso", {31'd0, miso}, 0);
        chk("rst miso_oe", {31'd0, miso_oe}, 0);
        chk("rst tx_ready", {31'd0, tx_ready}, 1);
        chk("rst rx_data", {24'd0, rx_data}, 0);
        chk("rst rx_valid", {31'd0, rx_valid}, 0);
        chk("rst tx_underrun", {31'd0, tx_underrun}, 0);
        chk("rst frame_err", {31'd0, frame_err}, 0);
        chk("rst busy", {31'd0, busy}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // T1: mode 0, A5 out, 3C in.
        case_tx = '{8'hA5};
        case_mosi = '{8'h3C};
        run_case("T1", 2'd0, 1);

        // T2: modes 1..3, 81 out, 7E in.
        for (int mm = 1; mm < 4; mm++) begin
            case_tx = '{8'h81};
            case_mosi = '{8'h7E};
            run_case($sformatf("T2m%0d", mm), mm[1:0], 1);
        end

        // T3: continuous two-word frame, second word written after tx_ready.
        case_tx = '{8'h11, 8'h22};
        case_mosi = '{8'hC3, 8'h5A};
        run_case("T3", 2'd0, 2);
        chk("T3 underrun_during_words", und_before_last, 0);

        // T4: empty buffer at ss fall.
        case_tx.delete();
        case_mosi = '{8'h96};
        run_case("T4", 2'd3, 1);

        // T5: ss released after 5 bits.
        prev_rx = rx_data;
        rxb   = rx_log.size();
        ferr0 = n_ferr;
        und0  = n_und;
        w     = 8'($urandom);
        txq.push_back(w);
        repeat (4) @(negedge clk);
        mq = '{8'hE7};
        misoq.delete();
        spi_xfer(2'd0, 5, 1'b0);
        ss = 1'b1;
        for (int k = 0; k < 3; k++) @(posedge clk);
        #1;
        chk("T5 miso_oe_drop", {31'd0, miso_oe}, 0);
        repeat (8) @(negedge clk);
        chk("T5 frame_err", n_ferr - ferr0, 1);
        chk("T5 rx_valid", rx_log.size() - rxb, 0);
        chk("T5 rx_data_held", {24'd0, rx_data}, {24'd0, prev_rx});
        chk("T5 underruns", n_und - und0, 0);

        // T6: reset part-way through a frame.
        w = 8'($urandom);
        txq.push_back(w);
        repeat (4) @(negedge clk);
        mq = '{8'h5C};
        misoq.delete();
        spi_xfer(2'd0, 4, 1'b0);
        rxb   = rx_log.size();
        ferr0 = n_ferr;
        rst = 1'b1; ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
        @(posedge clk);
        #1;
        chk("T6 miso", {31'd0, miso}, 0);
        chk("T6 miso_oe", {31'd0, miso_oe}, 0);
        chk("T6 tx_ready", {31'd0, tx_ready}, 1);
        chk("T6 rx_data", {24'd0, rx_data}, 0);
        chk("T6 busy", {31'd0, busy}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("T6 no_frame_err", n_ferr - ferr0, 0);
        chk("T6 no_rx_valid", rx_log.size() - rxb, 0);
        case_tx = '{8'($urandom)};
        case_mosi = '{8'($urandom)};
        run_case("T6 after", 2'($urandom_range(0, 3)), 1);

        // Randomised exchanges.
        for (int r = 0; r < 8; r++) begin
            m   = 2'($urandom_range(0, 3));
            nw  = $urandom_range(1, 3);
            ntx = $urandom_range(0, nw + (m[0] ? 0 : 1));
            case_tx.delete();
            case_mosi.delete();
            for (int k = 0; k < ntx; k++) case_tx.push_back(8'($urandom));
            for (int k = 0; k < nw; k++) case_mosi.push_back(8'($urandom));
            run_case($sformatf("R%0d", r), m, nw);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
